// File: rtl/wb_trace_unit.sv
// wb_trace_unit: captures each retiring micro-op at the MEM/WB latch and
// streams it off-chip as a 16-byte packet, MSB first, over a byte-wide
// valid/ready port. It never stalls the pipeline. When the record FIFO is
// full, a record is dropped and counted. Sequence numbers still advance on
// a drop, so gaps in the trace show where records were lost.
module wb_trace_unit #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          trace_en,
  input  logic          stall,
  input  logic [38:0]   DEBUG_uop_out,
  input  logic [15:0]   DEBUG_seqNPC_out,
  input  logic          DEBUG_taken_out,
  input  logic [15:0]   DEBUG_addr_out,
  input  logic [7:0]    DEBUG_rdata_out,
  input  logic [7:0]    DEBUG_wdata_out,
  input  logic [4:0]    Wr_id_out,
  input  logic [15:0]   Result_out,
  input  logic [7:0]    Flags_out,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  output logic          tx_sof,
  input  logic          tx_ready,
  output logic [AW:0]   fifo_level,
  output logic [7:0]    drop_cnt,
  output logic          overflow
);

  // Field order of this struct is the packet byte order (MSB first).
  typedef struct packed {
    logic [38:0] uop;
    logic [15:0] npc;
    logic        taken;
    logic [15:0] addr;
    logic [7:0]  rdata;
    logic [7:0]  wdata;
    logic [4:0]  wr_id;
    logic [15:0] result;
    logic [7:0]  flags;
    logic [10:0] seq;
  } trace_rec_t;

  typedef enum logic {IDLE, SEND} state_t;

  trace_rec_t     mem [DEPTH];
  trace_rec_t     wr_rec;
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [10:0]    seq;
  state_t         state;
  logic [127:0]   shift;
  logic [3:0]     byte_cnt;

  logic retire, full, push, pop, hs;

  // Fullness uses the pre-edge level: a same-edge pop never makes room.
  assign retire = trace_en && !stall && (DEBUG_uop_out != '0);
  assign full   = (fifo_level == (AW+1)'(DEPTH));
  assign push   = retire && !full;
  assign hs     = (state == SEND) && tx_ready;
  assign pop    = (fifo_level != '0) &&
                  ((state == IDLE) || (hs && (byte_cnt == 4'd15)));

  assign tx_valid = (state == SEND);
  assign tx_data  = shift[127:120];
  assign tx_sof   = (state == SEND) && (byte_cnt == 4'd0);

  // Assemble the record from the latch outputs and the running sequence number.
  always_comb begin
    wr_rec        = '0;
    wr_rec.uop    = DEBUG_uop_out;
    wr_rec.npc    = DEBUG_seqNPC_out;
    wr_rec.taken  = DEBUG_taken_out;
    wr_rec.addr   = DEBUG_addr_out;
    wr_rec.rdata  = DEBUG_rdata_out;
    wr_rec.wdata  = DEBUG_wdata_out;
    wr_rec.wr_id  = Wr_id_out;
    wr_rec.result = Result_out;
    wr_rec.flags  = Flags_out;
    wr_rec.seq    = seq;
  end

  // FIFO storage: no reset needed, the occupancy count guards every read.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= wr_rec;
  end

  // FIFO pointers, occupancy, sequence counter and drop accounting.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      seq        <= '0;
      drop_cnt   <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + (AW+1)'(1);
        2'b01:   fifo_level <= fifo_level - (AW+1)'(1);
        default: fifo_level <= fifo_level;
      endcase
      if (retire) seq <= seq + 11'd1;
      if (retire && full) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  // Serializer FSM: load a record, shift out one byte per accepted handshake,
  // and reload on the last byte so consecutive packets run back to back.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      shift    <= '0;
      byte_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shift    <= mem[rd_ptr];
            byte_cnt <= '0;
            state    <= SEND;
          end
        end
        SEND: begin
          if (tx_ready) begin
            if (byte_cnt == 4'd15 && pop) begin
              shift    <= mem[rd_ptr];
              byte_cnt <= '0;
            end else begin
              // After 16 shifts the register is all zero, so tx_data idles at 0.
              shift    <= shift << 8;
              byte_cnt <= byte_cnt + 4'd1;
              if (byte_cnt == 4'd15) state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_trace_unit.sv
// Bench for wb_trace_unit: a queue-level reference model tracks the record
// FIFO, the packet byte stream, and the drop counters. A negedge compare
// process checks every output against it. Directed tests also pin the model
// with hand-computed literal bytes, sequence numbers and timings.
module tb_wb_trace_unit;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic        CLK = 0, RST = 1;
  logic        trace_en = 0, stall = 0;
  logic [38:0] uop = '0;
  logic [15:0] npc = '0, addr = '0, res = '0;
  logic        taken = 0;
  logic [7:0]  rdata = '0, wdata = '0, flags = '0;
  logic [4:0]  wr_id = '0;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_sof;
  logic        tx_ready = 0;
  logic [AW:0] fifo_level;
  logic [7:0]  drop_cnt;
  logic        overflow;

  wb_trace_unit #(.DEPTH(DEPTH), .AW(AW)) dut (
    .CLK(CLK), .RST(RST), .trace_en(trace_en), .stall(stall),
    .DEBUG_uop_out(uop), .DEBUG_seqNPC_out(npc), .DEBUG_taken_out(taken),
    .DEBUG_addr_out(addr), .DEBUG_rdata_out(rdata), .DEBUG_wdata_out(wdata),
    .Wr_id_out(wr_id), .Result_out(res), .Flags_out(flags),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_sof(tx_sof), .tx_ready(tx_ready),
    .fifo_level(fifo_level), .drop_cnt(drop_cnt), .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  int n_pass = 0, n_tot = 0;
  bit mon_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // ---------------- reference model ----------------
  logic [127:0] mq[$];      // records waiting in the FIFO
  logic [7:0]   cur[$];     // bytes of the packet still to be sent
  int           m_drop = 0;
  bit           m_ovf = 0;
  int           m_seq = 0;

  function automatic logic [127:0] pack(input logic [10:0] s);
    return {uop, npc, taken, addr, rdata, wdata, wr_id, res, flags, s};
  endfunction

  initial forever begin
    int pq, pc;
    bit hs, pp;
    logic [127:0] r;
    @(posedge CLK or posedge RST);
    if (RST) begin
      mq.delete(); cur.delete(); m_drop = 0; m_ovf = 0; m_seq = 0;
    end else begin
      pq = mq.size(); pc = cur.size();
      hs = (pc > 0) && tx_ready;
      if (hs) void'(cur.pop_front());
      pp = (pq > 0) && (pc == 0 || (pc == 1 && hs));
      if (pp) begin
        r = mq.pop_front();
        for (int b = 0; b < 16; b++) cur.push_back(r[127-8*b -: 8]);
      end
      if (trace_en && !stall && uop != 0) begin
        if (pq < DEPTH) mq.push_back(pack(m_seq[10:0]));
        else begin
          if (m_drop < 255) m_drop++;
          m_ovf = 1;
        end
        m_seq = (m_seq + 1) % 2048;
      end
    end
  end

  // ---------------- compare process + byte logger ----------------
  logic [7:0] acc_log[$];
  bit         sof_log[$];

  always @(negedge CLK) begin
    if (mon_en && !RST) begin
      chk("valid", tx_valid, cur.size() > 0);
      if (cur.size() > 0) begin
        chk("data", tx_data, cur[0]);
        chk("sof", tx_sof, cur.size() == 16);
      end
      chk("level", fifo_level, mq.size());
      chk("drop_cnt", drop_cnt, m_drop);
      chk("overflow", overflow, m_ovf);
      if (tx_valid && tx_ready) begin
        acc_log.push_back(tx_data);
        sof_log.push_back(tx_sof);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick; @(posedge CLK); #1; endtask

  task automatic idle_in; trace_en = 0; stall = 0; uop = '0; endtask

  task automatic do_reset;
    RST = 1; tick; tick; RST = 0; idle_in; tx_ready = 0;
  endtask

  task automatic set_vec1;
    uop = 39'h1; npc = 16'h1234; taken = 1; addr = 16'hC000;
    rdata = 8'h5A; wdata = 8'hA5; wr_id = 5'd3; res = 16'hBEEF; flags = 8'h81;
  endtask

  task automatic set_rec(input int i);
    logic [31:0] v;
    v = i;
    uop = 39'h100 + 39'(v); npc = 16'h2000 + v[15:0]; taken = v[0];
    addr = 16'h8000 | v[15:0]; rdata = 8'h10 + v[7:0]; wdata = ~(8'h10 + v[7:0]);
    wr_id = v[4:0]; res = 16'hF000 ^ v[15:0]; flags = v[7:0];
  endtask

  task automatic wait_bytes(input int n, input int bound, input string nm);
    int k;
    k = 0;
    while (acc_log.size() < n && k < bound) begin tick; k++; end
    if (acc_log.size() < n) chk(nm, acc_log.size(), n);
  endtask

  function automatic int seq_at(input int base);
    logic [7:0] hi, lo;
    hi = acc_log[base+14]; lo = acc_log[base+15];
    return {hi[2:0], lo};
  endfunction

  // Packing of the first test vector, worked out field by field.
  logic [7:0] exp1 [16] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h24, 8'h69, 8'hC0,
                            8'h00, 8'h5A, 8'hA5, 8'h1D, 8'hF7, 8'h7C, 8'h08, 8'h00};
  int exp_seq [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 12};

  initial begin
    int base;
    bit v[52], s[52];

    // Reset state
    tick; tick;
    chk("rst_valid", tx_valid, 0); chk("rst_sof", tx_sof, 0); chk("rst_data", tx_data, 0);
    chk("rst_level", fifo_level, 0); chk("rst_drop", drop_cnt, 0); chk("rst_ovf", overflow, 0);
    RST = 0; mon_en = 1;

    // Test 1: single retire, literal bytes and latency
    tx_ready = 1; set_vec1; trace_en = 1;
    base = acc_log.size();
    tick; idle_in;
    chk("lat_e_valid", tx_valid, 0);
    tick;
    chk("lat_e1_valid", tx_valid, 1); chk("lat_e1_sof", tx_sof, 1);
    repeat (15) tick;
    chk("lat_e16_cnt", acc_log.size(), base + 15);
    tick;
    chk("lat_e17_cnt", acc_log.size(), base + 16);
    wait_bytes(base + 16, 10, "t1_timeout");
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t1_byte%0d", i), acc_log[base+i], exp1[i]);
      chk($sformatf("t1_sof%0d", i), sof_log[base+i], i == 0);
    end
    tick;
    chk("t1_level", fifo_level, 0);

    // Test 2: stall and bubble filter
    do_reset; tx_ready = 1;
    base = acc_log.size();
    set_vec1; trace_en = 1; stall = 1;
    repeat (3) begin tick; chk("t2_stall_valid", tx_valid, 0); end
    stall = 0; uop = '0;
    repeat (2) begin tick; chk("t2_bubble_valid", tx_valid, 0); end
    tick; chk("t2_none", acc_log.size(), base);
    uop = 39'h7; tick; idle_in;
    wait_bytes(base + 16, 40, "t2_timeout");
    chk("t2_seq", seq_at(base), 0);

    // Test 3: back-pressure at byte 7
    do_reset; tx_ready = 1;
    base = acc_log.size();
    set_vec1; trace_en = 1; tick; idle_in;
    wait_bytes(base + 7, 40, "t3_to7");
    tx_ready = 0;
    repeat (5) begin
      chk("t3_hold_valid", tx_valid, 1);
      chk("t3_hold_data", tx_data, exp1[7]);
      chk("t3_hold_sof", tx_sof, 0);
      tick;
    end
    tx_ready = 1;
    wait_bytes(base + 16, 40, "t3_timeout");
    for (int i = 0; i < 16; i++) chk($sformatf("t3_byte%0d", i), acc_log[base+i], exp1[i]);

    // Test 4: overflow with 12 retires against a stalled sink
    do_reset;
    base = acc_log.size();
    for (int i = 0; i < 12; i++) begin set_rec(i); trace_en = 1; tick; end
    idle_in; tick;
    chk("t4_level", fifo_level, 8); chk("t4_drop", drop_cnt, 3); chk("t4_ovf", overflow, 1);
    tx_ready = 1;
    wait_bytes(base + 144, 300, "t4_drain");
    set_rec(12); trace_en = 1; tick; idle_in;
    wait_bytes(base + 160, 60, "t4_last");
    for (int p = 0; p < 10; p++) chk($sformatf("t4_seq%0d", p), seq_at(base + 16*p), exp_seq[p]);
    chk("t4_drop_after", drop_cnt, 3); chk("t4_ovf_after", overflow, 1);

    // Test 5: three packets back to back
    do_reset;
    for (int i = 0; i < 3; i++) begin set_rec(40 + i); trace_en = 1; tick; end
    idle_in; tx_ready = 1;
    for (int c = 0; c < 52; c++) begin @(negedge CLK); v[c] = tx_valid; s[c] = tx_sof; end
    for (int c = 0; c < 48; c++) begin
      chk($sformatf("t5_valid%0d", c), v[c], 1);
      chk($sformatf("t5_sof%0d", c), s[c], (c % 16) == 0);
    end
    chk("t5_end_valid", v[48], 0);
    tick;

    // Test 6: async reset in the middle of a packet
    do_reset;
    for (int i = 0; i < 10; i++) begin set_rec(60 + i); trace_en = 1; tick; end
    idle_in; tick;
    chk("t6_pre_drop", drop_cnt, 1);
    base = acc_log.size();
    tx_ready = 1;
    wait_bytes(base + 9, 40, "t6_to9");
    chk("t6_pre_valid", tx_valid, 1);
    #2 RST = 1;
    #1;
    chk("t6_rst_valid", tx_valid, 0); chk("t6_rst_level", fifo_level, 0);
    chk("t6_rst_drop", drop_cnt, 0); chk("t6_rst_ovf", overflow, 0);
    chk("t6_rst_sof", tx_sof, 0);
    RST = 0;
    tick; chk("t6_no_resume", tx_valid, 0);
    base = acc_log.size();
    set_rec(99); trace_en = 1; tick; idle_in;
    wait_bytes(base + 16, 40, "t6_timeout");
    chk("t6_seq", seq_at(base), 0);
    chk("t6_sof", sof_log[base], 1);

    repeat (3) tick;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
